// File: rtl/spi_drv_pkg.sv
// spi_drv_pkg: shared constants and master state encoding for the SPI driver pair
package spi_drv_pkg;
  localparam int DATA_W = 8;
  localparam int HALF_PERIOD_DEF = 4;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} mst_state_e;
endpackage

// File: rtl/spi_master_core.sv
// spi_master_core: mode-0 MSB-first SPI master with a start/ready handshake
module spi_master_core #(
  parameter int HALF_PERIOD = spi_drv_pkg::HALF_PERIOD_DEF,
  parameter int DATA_W = spi_drv_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_in_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_out_o,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic              sclk_o,
  output logic              cs_o
);
  localparam int CW = spi_drv_pkg::CNT_W;
  localparam int BW = $clog2(DATA_W);
  spi_drv_pkg::mst_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, out_q, out_d;
  logic phase_end, last_bit, launch;
  assign phase_end = cnt_q == CW'(HALF_PERIOD - 1);
  assign last_bit = bit_q == BW'(DATA_W - 1);
  assign launch = state_q == spi_drv_pkg::IDLE && start_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= spi_drv_pkg::IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      out_q <= out_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      spi_drv_pkg::IDLE:  state_d = start_i ? spi_drv_pkg::SETUP : spi_drv_pkg::IDLE;
      spi_drv_pkg::SETUP: state_d = phase_end ? spi_drv_pkg::HIGH : spi_drv_pkg::SETUP;
      spi_drv_pkg::HIGH:  state_d = phase_end ? spi_drv_pkg::LOW : spi_drv_pkg::HIGH;
      spi_drv_pkg::LOW:   state_d = !phase_end ? spi_drv_pkg::LOW : last_bit ? spi_drv_pkg::HOLD : spi_drv_pkg::HIGH;
      spi_drv_pkg::HOLD:  state_d = phase_end ? spi_drv_pkg::GAP : spi_drv_pkg::HOLD;
      spi_drv_pkg::GAP:   state_d = phase_end ? spi_drv_pkg::IDLE : spi_drv_pkg::GAP;
      default:            state_d = spi_drv_pkg::IDLE;
    endcase
    cnt_d = (state_q == spi_drv_pkg::IDLE || phase_end) ? '0 : cnt_q + 1'b1;
    bit_d = (state_q == spi_drv_pkg::IDLE) ? '0 : (state_q == spi_drv_pkg::LOW && phase_end) ? bit_q + 1'b1 : bit_q;
    tx_d = launch ? data_in_i : (state_q == spi_drv_pkg::HIGH && phase_end) ? {tx_q[DATA_W-2:0], 1'b0} : tx_q;
    // MISO is sampled on the cycle SCLK rises, long after the slave set it up
    rx_d = (state_d == spi_drv_pkg::HIGH && state_q != spi_drv_pkg::HIGH) ? {rx_q[DATA_W-2:0], miso_i} : rx_q;
    out_d = (state_q == spi_drv_pkg::GAP && phase_end) ? rx_q : out_q;
  end
  always_comb begin
    ready_o = state_q == spi_drv_pkg::IDLE;
    cs_o = state_q == spi_drv_pkg::IDLE || state_q == spi_drv_pkg::GAP;
    sclk_o = state_q == spi_drv_pkg::HIGH;
    mosi_o = (state_q == spi_drv_pkg::IDLE || state_q == spi_drv_pkg::GAP) ? 1'b0 : tx_q[DATA_W-1];
    data_out_o = out_q;
  end
endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: mode-0 MSB-first SPI slave oversampling its pins in the clk_i domain
module spi_slave_core #(
  parameter int DATA_W = spi_drv_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_in_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_out_o,
  output logic              miso_o,
  input  logic              mosi_i,
  input  logic              sclk_i,
  input  logic              cs_i
);
  logic sclk_s, cs_s, mosi_s;
  logic sclk_p_q, cs_p_q, ready_q, ready_d, miso_q, miso_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, out_q, out_d;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  // CS synchronizer resets high so leaving reset never looks like a deselect edge
  spi_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk_i, .rst_i, .d_i(sclk_i), .q_o(sclk_s));
  spi_sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk_i, .rst_i, .d_i(cs_i),   .q_o(cs_s));
  spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk_i, .rst_i, .d_i(mosi_i), .q_o(mosi_s));
  assign cs_fall = cs_p_q && !cs_s;
  assign cs_rise = !cs_p_q && cs_s;
  assign sclk_rise = !sclk_p_q && sclk_s && !cs_s;
  assign sclk_fall = sclk_p_q && !sclk_s && !cs_s;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_p_q <= 1'b0;
      cs_p_q <= 1'b1;
      ready_q <= 1'b1;
      miso_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      out_q <= '0;
    end else begin
      sclk_p_q <= sclk_s;
      cs_p_q <= cs_s;
      ready_q <= ready_d;
      miso_q <= miso_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      out_q <= out_d;
    end
  end
  always_comb begin
    ready_d = cs_fall ? 1'b0 : cs_rise ? 1'b1 : ready_q;
    tx_d = cs_fall ? data_in_i : sclk_fall ? {tx_q[DATA_W-2:0], 1'b0} : tx_q;
    rx_d = cs_fall ? '0 : sclk_rise ? {rx_q[DATA_W-2:0], mosi_s} : rx_q;
    miso_d = cs_fall ? data_in_i[DATA_W-1] : cs_rise ? 1'b0 : sclk_fall ? tx_q[DATA_W-2] : miso_q;
    out_d = cs_rise ? rx_q : out_q;
  end
  assign ready_o = ready_q;
  assign miso_o = miso_q;
  assign data_out_o = out_q;
endmodule

// File: rtl/spi_sync2.sv
// spi_sync2: two-flop synchronizer with a selectable reset level
module spi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/spi_driver_pair.sv
// spi_driver_pair: independent SPI master and slave drivers sharing one clock domain
module spi_driver_pair #(
  parameter int HALF_PERIOD = spi_drv_pkg::HALF_PERIOD_DEF,
  parameter int DATA_W = spi_drv_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m_start_i,
  input  logic [DATA_W-1:0] m_data_in_bi,
  output logic              m_ready_o,
  output logic [DATA_W-1:0] m_data_out_bo,
  input  logic              m_spi_miso_i,
  output logic              m_spi_mosi_o,
  output logic              m_spi_sclk_o,
  output logic              m_spi_cs_o,
  input  logic [DATA_W-1:0] s_data_in_bi,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] s_data_out_bo,
  output logic              s_spi_miso_o,
  input  logic              s_spi_mosi_i,
  input  logic              s_spi_sclk_i,
  input  logic              s_spi_cs_i
);
  spi_master_core #(.HALF_PERIOD(HALF_PERIOD), .DATA_W(DATA_W)) u_master (
    .clk_i, .rst_i,
    .start_i(m_start_i), .data_in_i(m_data_in_bi),
    .ready_o(m_ready_o), .data_out_o(m_data_out_bo),
    .miso_i(m_spi_miso_i), .mosi_o(m_spi_mosi_o),
    .sclk_o(m_spi_sclk_o), .cs_o(m_spi_cs_o)
  );
  spi_slave_core #(.DATA_W(DATA_W)) u_slave (
    .clk_i, .rst_i,
    .data_in_i(s_data_in_bi),
    .ready_o(s_ready_o), .data_out_o(s_data_out_bo),
    .miso_o(s_spi_miso_o), .mosi_i(s_spi_mosi_i),
    .sclk_i(s_spi_sclk_i), .cs_i(s_spi_cs_i)
  );
endmodule

// File: tb/tb_spi_driver_pair.sv
// tb_spi_driver_pair: loopback and standalone-slave bench for spi_driver_pair
module tb_spi_driver_pair;
  localparam int HP = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic m_start = 1'b0;
  logic [7:0] m_din = '0, s_din = '0, m_dout, s_dout;
  logic m_ready, s_ready, m_miso, m_mosi, m_sclk, m_cs, s_miso, s_mosi, s_sclk, s_cs;
  logic loop_en = 1'b1, tb_sclk = 1'b0, tb_cs = 1'b1, tb_mosi = 1'b0;
  assign m_miso = s_miso;
  assign s_mosi = loop_en ? m_mosi : tb_mosi;
  assign s_sclk = loop_en ? m_sclk : tb_sclk;
  assign s_cs = loop_en ? m_cs : tb_cs;

  spi_driver_pair #(.HALF_PERIOD(HP), .DATA_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_start_i(m_start), .m_data_in_bi(m_din), .m_ready_o(m_ready), .m_data_out_bo(m_dout),
    .m_spi_miso_i(m_miso), .m_spi_mosi_o(m_mosi), .m_spi_sclk_o(m_sclk), .m_spi_cs_o(m_cs),
    .s_data_in_bi(s_din), .s_ready_o(s_ready), .s_data_out_bo(s_dout),
    .s_spi_miso_o(s_miso), .s_spi_mosi_i(s_mosi), .s_spi_sclk_i(s_sclk), .s_spi_cs_i(s_cs)
  );

  typedef struct {logic [7:0] m_tx, s_tx, exp_m, exp_s;} vec_t;
  typedef struct {logic [7:0] m, s;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  int low_cnt = 0, last_low = 0, cs_hi = 0, last_cs_hi = 0, cs_falls = 0, rises = 0;
  int rise_base = 0, fall_base = 0;
  logic [7:0] mosi_cap = '0;

  always @(posedge clk) begin
    if (!m_ready) low_cnt <= low_cnt + 1;
    else if (low_cnt != 0) begin
      last_low <= low_cnt;
      low_cnt <= 0;
    end
    if (m_cs) cs_hi <= cs_hi + 1;
    else if (cs_hi != 0) begin
      last_cs_hi <= cs_hi;
      cs_hi <= 0;
      cs_falls <= cs_falls + 1;
    end
  end

  always @(posedge m_sclk) begin
    rises <= rises + 1;
    mosi_cap <= {mosi_cap[6:0], m_mosi};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (!(m_ready && s_ready) && i < 400) begin
      @(negedge clk);
      i++;
    end
    check({name, "_idle"}, 32'(m_ready && s_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] mt, st, em, es);
    m_din = mt;
    s_din = st;
    rise_base = rises;
    fall_base = cs_falls;
    sb.push_back('{m: em, s: es});
    m_start = 1'b1;
    @(posedge clk);
    #1 m_start = 1'b0;
  endtask

  task automatic finish_frame(input string name, input logic [7:0] mt);
    exp_t e;
    wait_idle(name);
    e = sb.pop_front();
    check({name, "_m_rx"}, m_dout, e.m);
    check({name, "_s_rx"}, s_dout, e.s);
    check({name, "_mosi_bits"}, mosi_cap, mt);
    check({name, "_ready_low"}, last_low, 19 * HP);
    check({name, "_sclk_rises"}, rises - rise_base, 8);
  endtask

  task automatic sclk_pulse(input logic b);
    tb_mosi = b;
    repeat (6) @(posedge clk);
    #1 tb_sclk = 1'b1;
    repeat (6) @(posedge clk);
    #1 tb_sclk = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    exp_t e;
    int i;
    vt = '{'{8'hA5, 8'h3C, 8'h3C, 8'hA5}, '{8'h00, 8'hFF, 8'hFF, 8'h00},
           '{8'hFF, 8'h00, 8'h00, 8'hFF}, '{8'h81, 8'h7E, 8'h7E, 8'h81},
           '{8'h5A, 8'hA5, 8'hA5, 8'h5A}, '{8'h01, 8'h80, 8'h80, 8'h01}};
    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_m_ready", m_ready, 1);
    check("rst_m_cs", m_cs, 1);
    check("rst_m_sclk", m_sclk, 0);
    check("rst_m_mosi", m_mosi, 0);
    check("rst_m_dout", m_dout, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_s_dout", s_dout, 0);
    check("rst_s_miso", s_miso, 0);
    // loopback frames from the table
    for (int k = 0; k < 6; k++) begin
      pulse_start(vt[k].m_tx, vt[k].s_tx, vt[k].exp_m, vt[k].exp_s);
      finish_frame($sformatf("vec%0d", k), vt[k].m_tx);
    end
    // start held 10 cycles gives one frame only
    m_din = 8'h42;
    s_din = 8'h24;
    rise_base = rises;
    fall_base = cs_falls;
    sb.push_back('{m: 8'h24, s: 8'h42});
    m_start = 1'b1;
    repeat (10) @(posedge clk);
    #1 m_start = 1'b0;
    finish_frame("held10", 8'h42);
    repeat (10) @(posedge clk);
    #1 check("held10_frames", cs_falls - fall_base, 1);
    // start held across two frames
    m_din = 8'hFF;
    s_din = 8'h5A;
    rise_base = rises;
    fall_base = cs_falls;
    sb.push_back('{m: 8'h5A, s: 8'hFF});
    m_start = 1'b1;
    repeat (12) @(posedge clk);
    #1 m_din = 8'h00;
    s_din = 8'hC3;
    i = 0;
    while (!m_ready && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("b2b_f1_ready", m_ready, 1);
    e = sb.pop_front();
    check("b2b_f1_m_rx", m_dout, e.m);
    check("b2b_f1_s_rx", s_dout, e.s);
    check("b2b_f1_mosi_bits", mosi_cap, 8'hFF);
    sb.push_back('{m: 8'hC3, s: 8'h00});
    @(posedge clk);
    #1 check("b2b_relaunch", m_ready, 0);
    check("b2b_f1_ready_low", last_low, 19 * HP);
    m_start = 1'b0;
    rise_base = rises;
    finish_frame("b2b_f2", 8'h00);
    check("b2b_cs_gap", 32'(last_cs_hi >= HP), 1);
    check("b2b_frames", cs_falls - fall_base, 2);
    // reset in the middle of a frame
    m_din = 8'h96;
    s_din = 8'h69;
    rise_base = rises;
    m_start = 1'b1;
    @(posedge clk);
    #1 m_start = 1'b0;
    i = 0;
    while (rises - rise_base < 3 && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("midrst_3rd_rise", rises - rise_base, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_m_cs", m_cs, 1);
    check("midrst_m_sclk", m_sclk, 0);
    check("midrst_m_ready", m_ready, 1);
    check("midrst_m_dout", m_dout, 0);
    repeat (4) @(posedge clk);
    #1 check("midrst_s_ready", s_ready, 1);
    check("midrst_s_dout", s_dout, 0);
    pulse_start(8'h96, 8'h69, 8'h69, 8'h96);
    finish_frame("after_rst", 8'h96);
    // slave driven alone with a 4-bit partial frame
    loop_en = 1'b0;
    s_din = 8'h80;
    repeat (4) @(posedge clk);
    #1 tb_cs = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("solo_s_ready_sel", s_ready, 0);
    check("solo_s_miso_msb", s_miso, 1);
    sclk_pulse(1'b1);
    check("solo_s_miso_bit6", s_miso, 0);
    sclk_pulse(1'b0);
    sclk_pulse(1'b1);
    sclk_pulse(1'b1);
    check("solo_s_ready_busy", s_ready, 0);
    tb_cs = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("solo_s_ready_done", s_ready, 1);
    check("solo_s_dout", s_dout, 8'h0B);
    check("solo_s_miso_idle", s_miso, 0);
    check("solo_m_ready", m_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
